// File: rtl/seq_shifter_dlx_pkg.sv
// Shared encodings for the multi-cycle DLX shift unit.
// Rotate support is controlled by SEQ_SHIFTER_ROTATE_EN.
package seq_shifter_dlx_pkg;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_dlx.sv
// Combinational single-bit shift/rotate step.
// Rotates exist only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step_dlx
    import seq_shifter_dlx_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] stepped
);

    always_comb begin
        stepped = {data[WIDTH-2:0], 1'b0};
        case (mode)
            MODE_SRL: stepped = {1'b0, data[WIDTH-1:1]};
            MODE_SRA: stepped = {data[WIDTH-1], data[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
            MODE_ROL: stepped = {data[WIDTH-2:0], data[WIDTH-1]};
            MODE_ROR: stepped = {data[0], data[WIDTH-1:1]};
`else
            // Without rotates, ROR degrades to a logical right shift
            MODE_ROR: stepped = {1'b0, data[WIDTH-1:1]};
`endif
            default: stepped = {data[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/seq_shifter_dlx.sv
// Multi-cycle shifter: one bit position per clock, start/busy/done handshake.
// Optional rotate modes via SEQ_SHIFTER_ROTATE_EN.
module seq_shifter_dlx
    import seq_shifter_dlx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       MODE,
    input  logic [AMT_W-1:0] AMT,
    input  logic [WIDTH-1:0] DI,
    output logic [WIDTH-1:0] DO,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state;
    logic [AMT_W-1:0] count;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] stepped;

    shift_step_dlx #(
        .WIDTH(WIDTH)
    ) u_step (
        .data   (DO),
        .mode   (mode_q),
        .stepped(stepped)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            DO     <= '0;
            count  <= '0;
            mode_q <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    DO    <= stepped;
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= ST_FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                ST_IDLE, ST_FIN: begin
                    // FIN also accepts, giving back-to-back operation
                    if (START) begin
                        DO     <= DI;
                        mode_q <= MODE;
                        count  <= AMT;
                        if (AMT == '0) begin
                            state <= ST_FIN;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            BUSY  <= 1'b1;
                            DONE  <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule
